vga_line_fetch: RTL
===================

# vga_line_fetch

- DDR3 read-side line fetcher feeding the VGA scan-out stage.
- On each line request from the display timing logic, issues read bursts on MCB port 1 (`c3_p1_*`), drains the port read FIFO and writes one scan line of 32-bit words into the display line buffer.
- Sits between `qm_ddr3` port 1 and the VGA pixel serializer, in the `clk_100m` domain.

## Interface
Parameters:
- `BURST_WORDS`, 32: 32-bit words per MCB read command, 1..64; `c3_p1_cmd_bl = BURST_WORDS-1`.
- `LINE_WORDS`, 512: words per line (1024 px × 16 bpp); must be a multiple of `BURST_WORDS`.
- `BUF_AW`, 9: line-buffer word address width; `2^BUF_AW >= LINE_WORDS`.

Ports:
- `sys_clk` in 1: single clock (`clk_100m`). Everything is in this domain.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `line_req` in 1: one-cycle start pulse.
- `line_base_addr` in 30: DDR byte address of word 0, 4-byte aligned.
- `line_busy` out 1: high from request acceptance until `line_done`.
- `line_done` out 1: one-cycle pulse, last word written.
- `c3_p1_cmd_en` out 1: MCB command strobe.
- `c3_p1_cmd_full` in 1: MCB command FIFO full.
- `c3_p1_cmd_rw` out 1: command type, 1 = read.
- `c3_p1_cmd_bl` out 6: burst length − 1.
- `c3_p1_cmd_byte_addr` out 30: burst start address.
- `c3_p1_rd_en` out 1: pops the MCB read FIFO.
- `c3_p1_rd_data` in 32: MCB read FIFO head; first-word-fall-through.
- `c3_p1_rd_empty` in 1: MCB read FIFO empty.
- `buf_wr_en` out 1: line-buffer write strobe.
- `buf_wr_addr` out BUF_AW: word index within the line.
- `buf_wr_data` out 32: write data.
- `fetch_overrun` out 1: sticky; exists only under `VGA_LINE_FETCH_OVERRUN_EN`.

## Operation
- States: `IDLE`, `CMD`, `DRAIN`, `DONE`.
- **IDLE:** on `line_req`:
  - latch `line_base_addr`;
  - clear the word counter `wcnt` and the burst word counter `bcnt`;
  - set `line_busy`;
  - go to `CMD`.
- **CMD:** when `c3_p1_cmd_full==0`:
  - pulse `c3_p1_cmd_en` for exactly one cycle with `c3_p1_cmd_rw=1`, `c3_p1_cmd_bl=BURST_WORDS-1`, `c3_p1_cmd_byte_addr = base + wcnt*4`;
  - go to `DRAIN`.
  - While `cmd_full` is high, wait with no strobe.
- **DRAIN:**
  - `c3_p1_rd_en = !c3_p1_rd_empty` (combinational, DRAIN only).
  - Each pop captures `c3_p1_rd_data` into `buf_wr_data`, with `buf_wr_addr=wcnt`; increments `wcnt` and `bcnt`.
  - After `BURST_WORDS` pops: if `wcnt==LINE_WORDS`, go to `DONE`; otherwise clear `bcnt` and go to `CMD`.
  - At most one burst is outstanding at any time.
- **DONE:** pulse `line_done`, clear `line_busy`, go to `IDLE`.
- **Address arithmetic:** modulo 2^30, so a line crossing the top of memory wraps to 0. `buf_wr_addr` never exceeds `LINE_WORDS-1`.
- **`line_req` while busy:** ignored; the current line continues unaltered.
- **Reset mid-line:** all state returns to `IDLE` and all outputs go to 0. The MCB port is reset together with this block, so no read-FIFO flush is performed.

## Timing
- Reset values: `line_busy`, `line_done`, `c3_p1_cmd_en`, `c3_p1_cmd_rw`, `c3_p1_rd_en`, `buf_wr_en`, `fetch_overrun` = 0; `c3_p1_cmd_bl`, `c3_p1_cmd_byte_addr`, `buf_wr_addr`, `buf_wr_data` = 0.
- `line_req` at cycle 0:
  - `line_busy` is high from cycle 1;
  - the first `cmd_en` is at cycle 2 if `cmd_full` is low.
- `cmd_en`, `cmd_bl`, `cmd_byte_addr` are registered and valid in the same cycle.
- `buf_wr_en` is registered: it is high exactly 1 cycle after each pop, carrying the data popped in that pop.
- `line_done` pulses 1 cycle after the last `buf_wr_en`. `line_busy` falls in the same cycle as `line_done`.
- Next `cmd_en` is 1 cycle after the last pop of the previous burst, when `cmd_full` is low.
- Back-to-back: a `line_req` in the cycle after `line_done` is accepted.

## Configuration
- Macro: `VGA_LINE_FETCH_OVERRUN_EN`.
- **Defined:** `fetch_overrun` exists. It sets on any `line_req` arriving while `line_busy` is high, or while in `DONE`. It clears only on reset.
- **Undefined:** the port and its logic are absent; late requests are silently ignored.

## Test plan
- **Base case:** `BURST_WORDS=32`, `LINE_WORDS=512`, base `0x0000_1000`, MCB model returns incrementing data with no stalls → 16 `cmd_en` pulses at addresses `0x1000, 0x1080, …, 0x1780`, each with `bl=31`, `rw=1`; 512 `buf_wr_en` with addresses 0..511 and data matching; exactly one `line_done`.
- **Command back-pressure:** hold `cmd_full=1` for 10 cycles at the 3rd command → no `cmd_en` while full; that command issues 1 cycle after `cmd_full` falls, at address `base+0x100`.
- **Read FIFO starvation:** toggle `rd_empty` every cycle → `rd_en` never asserted while empty; all 512 words written in order; total `buf_wr_en` count is 512.
- **Address wrap:** base `0x3FFF_FF80` → second command address is `0x0000_0000`.
- **Request during a line:** `line_req` pulsed mid-line, then again 1 cycle after `line_done` → the first is ignored, with `fetch_overrun=1` if the macro is defined; the second starts a new line normally.
- **Reset mid-line:** `sys_rst_n=0` for 1 cycle during `DRAIN` → the next cycle shows all outputs 0, `line_busy=0`, and the FSM in `IDLE`; a new `line_req` restarts at word 0.

Source files
------------

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches one scan line from DDR3 (MCB port 1) in bursts and writes it to the line buffer.
// Optional sticky fetch_overrun flag for late requests: define VGA_LINE_FETCH_OVERRUN_EN.
module vga_line_fetch #(
    parameter int BURST_WORDS = 32,
    parameter int LINE_WORDS  = 512,
    parameter int BUF_AW      = 9
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              line_req,
    input  logic [29:0]       line_base_addr,
    output logic              line_busy,
    output logic              line_done,
    output logic              c3_p1_cmd_en,
    input  logic              c3_p1_cmd_full,
    output logic              c3_p1_cmd_rw,
    output logic [5:0]        c3_p1_cmd_bl,
    output logic [29:0]       c3_p1_cmd_byte_addr,
    output logic              c3_p1_rd_en,
    input  logic [31:0]       c3_p1_rd_data,
    input  logic              c3_p1_rd_empty,
    output logic              buf_wr_en,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [31:0]       buf_wr_data
`ifdef VGA_LINE_FETCH_OVERRUN_EN
    ,
    output logic              fetch_overrun
`endif
);
    localparam int WCW = $clog2(LINE_WORDS + 1);
    localparam int BCW = $clog2(BURST_WORDS + 1);
    localparam logic [5:0]     CMD_BL    = 6'(BURST_WORDS - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(LINE_WORDS - 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r;
    logic [29:0]    base_r;
    logic [WCW-1:0] wcnt_r;
    logic [BCW-1:0] bcnt_r;
    logic           pop_s;
    logic [WCW-1:0] wcnt_next_s;
    logic [29:0]    issue_addr_s;

    // Pop strobe and address of the next burst; in DRAIN the next burst starts after the word being popped.
    always_comb begin
        pop_s        = 1'b0;
        wcnt_next_s  = wcnt_r + WCW'(1);
        issue_addr_s = 30'd0;
        if (state_r == DRAIN && !c3_p1_rd_empty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (state_r == DRAIN) begin
            issue_addr_s = base_r + 30'({wcnt_next_s, 2'b00});
        end else begin
            issue_addr_s = base_r + 30'({wcnt_r, 2'b00});
        end
    end

    assign c3_p1_rd_en = pop_s;

    // Line fetch sequencer with registered command, buffer-write and handshake outputs.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r             <= IDLE;
            base_r              <= 30'd0;
            wcnt_r              <= '0;
            bcnt_r              <= '0;
            line_busy           <= 1'b0;
            line_done           <= 1'b0;
            c3_p1_cmd_en        <= 1'b0;
            c3_p1_cmd_rw        <= 1'b0;
            c3_p1_cmd_bl        <= 6'd0;
            c3_p1_cmd_byte_addr <= 30'd0;
            buf_wr_en           <= 1'b0;
            buf_wr_addr         <= '0;
            buf_wr_data         <= 32'd0;
        end else begin
            c3_p1_cmd_en <= 1'b0;
            line_done    <= 1'b0;
            buf_wr_en    <= pop_s;
            if (pop_s) begin
                buf_wr_addr <= BUF_AW'(wcnt_r);
                buf_wr_data <= c3_p1_rd_data;
            end
            case (state_r)
                IDLE: begin
                    if (line_req) begin
                        base_r    <= line_base_addr;
                        wcnt_r    <= '0;
                        bcnt_r    <= '0;
                        line_busy <= 1'b1;
                        state_r   <= CMD;
                    end
                end
                CMD: begin
                    if (!c3_p1_cmd_full) begin
                        c3_p1_cmd_en        <= 1'b1;
                        c3_p1_cmd_rw        <= 1'b1;
                        c3_p1_cmd_bl        <= CMD_BL;
                        c3_p1_cmd_byte_addr <= issue_addr_s;
                        state_r             <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_s) begin
                        wcnt_r <= wcnt_next_s;
                        if (bcnt_r == LAST_BEAT) begin
                            bcnt_r <= '0;
                            if (wcnt_r == LAST_WORD) begin
                                state_r <= DONE;
                            end else if (!c3_p1_cmd_full) begin
                                // Issue the next burst straight away: the previous one is fully drained.
                                c3_p1_cmd_en        <= 1'b1;
                                c3_p1_cmd_rw        <= 1'b1;
                                c3_p1_cmd_bl        <= CMD_BL;
                                c3_p1_cmd_byte_addr <= issue_addr_s;
                                state_r             <= DRAIN;
                            end else begin
                                state_r <= CMD;
                            end
                        end else begin
                            bcnt_r <= bcnt_r + BCW'(1);
                        end
                    end
                end
                DONE: begin
                    line_done <= 1'b1;
                    line_busy <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef VGA_LINE_FETCH_OVERRUN_EN
    // Sticky flag for requests arriving while a line is still in flight.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            fetch_overrun <= 1'b0;
        end else if (line_req && (line_busy || state_r == DONE)) begin
            fetch_overrun <= 1'b1;
        end else begin
            fetch_overrun <= fetch_overrun;
        end
    end
`endif

endmodule
